// File: rtl/rf_sequencer_pkg.sv
// Shared definitions for the rf_sequencer slice: default widths, opcode map,
// ALU operation encodings and sequencer state encoding.
package rf_sequencer_pkg;

  localparam int unsigned RFW_DEFAULT = 2;
  localparam int unsigned DW_DEFAULT  = 8;

  // Opcodes (instr[7:4])
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_MOV  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_NOT  = 4'h7;
  localparam logic [3:0] OP_LDI  = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_BRZ  = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hF;

  // ALU operations
  localparam logic [2:0] ALU_MOV = 3'd0;
  localparam logic [2:0] ALU_ADD = 3'd1;
  localparam logic [2:0] ALU_SUB = 3'd2;
  localparam logic [2:0] ALU_AND = 3'd3;
  localparam logic [2:0] ALU_OR  = 3'd4;
  localparam logic [2:0] ALU_XOR = 3'd5;
  localparam logic [2:0] ALU_NOT = 3'd6;

  // Sequencer states
  localparam logic [2:0] ST_INIT      = 3'd0;
  localparam logic [2:0] ST_FETCH     = 3'd1;
  localparam logic [2:0] ST_DECODE    = 3'd2;
  localparam logic [2:0] ST_FETCH_IMM = 3'd3;
  localparam logic [2:0] ST_WB        = 3'd4;
  localparam logic [2:0] ST_HALT      = 3'd5;

endpackage

// File: rtl/rf_sequencer_decode.sv
// Combinational opcode-to-control decoder for rf_sequencer.
module rf_seq_decode
  import rf_sequencer_pkg::*;
(
  input  logic [3:0] opcode,
  output logic [2:0] alu_op,
  output logic       is_alu,
  output logic       is_ldi,
  output logic       is_jmp,
  output logic       is_brz,
  output logic       needs_imm,
  output logic       is_halt,
  output logic       is_illegal
);

  // Classify the opcode; anything unlisted behaves as NOP
  always_comb begin
    alu_op     = ALU_MOV;
    is_alu     = 1'b0;
    is_ldi     = 1'b0;
    is_jmp     = 1'b0;
    is_brz     = 1'b0;
    is_halt    = 1'b0;
    is_illegal = 1'b0;
    case (opcode)
      OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT: begin
        is_alu = 1'b1;
        alu_op = opcode[2:0] - 3'd1;
      end
      OP_LDI:                      is_ldi     = 1'b1;
      OP_JMP:                      is_jmp     = 1'b1;
      OP_BRZ:                      is_brz     = 1'b1;
      OP_HALT:                     is_halt    = 1'b1;
      4'hB, 4'hC, 4'hD, 4'hE:      is_illegal = 1'b1;
      default: ;
    endcase
    needs_imm = is_ldi | is_jmp | is_brz;
  end

endmodule

// File: rtl/rf_sequencer.sv
// Instruction sequencer driving a small register file: fetch, decode,
// optional immediate fetch, write-back, halt.
module rf_sequencer
  import rf_sequencer_pkg::*;
#(
  parameter int unsigned RFW = RFW_DEFAULT,
  parameter int unsigned DW  = DW_DEFAULT
) (
  input  logic           clk,
  input  logic           reset,
  output logic [DW-1:0]  imem_addr,
  output logic           fetch_req,
  input  logic           fetch_ack,
  input  logic [DW-1:0]  instr,
  input  logic [DW-1:0]  reg1data,
  output logic           rf_reset,
  output logic           rf_we,
  output logic [RFW-1:0] reg1,
  output logic [RFW-1:0] reg2,
  output logic [RFW-1:0] wreg,
  output logic [2:0]     alu_op,
  output logic           wdata_sel,
  output logic [DW-1:0]  imm,
  output logic           halted,
  output logic           illegal
);

  logic [2:0]    state;
  logic [DW-1:0] pc;
  logic [DW-1:0] ir;
  logic [DW-1:0] imm_q;

  logic [2:0] dec_alu_op;
  logic       is_alu, is_ldi, is_jmp, is_brz, needs_imm, is_halt, is_illegal;

  rf_seq_decode u_decode (
    .opcode     (ir[7:4]),
    .alu_op     (dec_alu_op),
    .is_alu     (is_alu),
    .is_ldi     (is_ldi),
    .is_jmp     (is_jmp),
    .is_brz     (is_brz),
    .needs_imm  (needs_imm),
    .is_halt    (is_halt),
    .is_illegal (is_illegal)
  );

  // Sequencer FSM plus PC, IR and immediate registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_INIT;
      pc    <= '0;
      ir    <= '0;
      imm_q <= '0;
    end else begin
      case (state)
        ST_INIT: state <= ST_FETCH;
        ST_FETCH: begin
          if (fetch_ack) begin
            ir    <= instr;
            pc    <= pc + DW'(1);
            state <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (is_alu)         state <= ST_WB;
          else if (needs_imm) state <= ST_FETCH_IMM;
          else if (is_halt)   state <= ST_HALT;
          else                state <= ST_FETCH;
        end
        ST_FETCH_IMM: begin
          if (fetch_ack) begin
            imm_q <= instr;
            if (is_jmp || (is_brz && reg1data == '0)) pc <= instr;
            else                                       pc <= pc + DW'(1);
            state <= is_ldi ? ST_WB : ST_FETCH;
          end
        end
        ST_WB:   state <= ST_FETCH;
        ST_HALT: state <= ST_HALT;
        default: state <= ST_INIT;
      endcase
    end
  end

  // Outputs; register addresses come straight from IR so they stay stable
  // through WB. rf_reset is masked while reset is held so that every output
  // reads zero during reset even though the state is already INIT.
  always_comb begin
    imem_addr = pc;
    fetch_req = (state == ST_FETCH) || (state == ST_FETCH_IMM);
    rf_we     = (state == ST_WB);
    rf_reset  = (state == ST_INIT) && !reset;
    halted    = (state == ST_HALT);
    illegal   = (state == ST_DECODE) && is_illegal;
    reg1      = RFW'(ir[3:2]);
    reg2      = RFW'(ir[1:0]);
    wreg      = RFW'(ir[3:2]);
    alu_op    = dec_alu_op;
    wdata_sel = is_ldi;
    imm       = imm_q;
  end

endmodule

// File: tb/tb_rf_sequencer.sv
// Self-checking bench for rf_sequencer: instruction-memory responder driven
// from the main thread, write-back scoreboard checked by a negedge monitor.
module tb_rf_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] imem_addr;
  logic       fetch_req;
  logic       fetch_ack;
  logic [7:0] instr;
  logic [7:0] reg1data;
  logic       rf_reset, rf_we;
  logic [1:0] reg1, reg2, wreg;
  logic [2:0] alu_op;
  logic       wdata_sel;
  logic [7:0] imm;
  logic       halted, illegal;

  rf_sequencer #(.RFW(2), .DW(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .imem_addr (imem_addr),
    .fetch_req (fetch_req),
    .fetch_ack (fetch_ack),
    .instr     (instr),
    .reg1data  (reg1data),
    .rf_reset  (rf_reset),
    .rf_we     (rf_we),
    .reg1      (reg1),
    .reg2      (reg2),
    .wreg      (wreg),
    .alu_op    (alu_op),
    .wdata_sel (wdata_sel),
    .imm       (imm),
    .halted    (halted),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] wreg;
    logic [1:0] reg1;
    logic [1:0] reg2;
    logic [2:0] alu_op;
    logic       wdata_sel;
    logic [7:0] imm;
  } wb_t;

  wb_t sb[$];
  wb_t mon_e;
  int  nvec = 0;
  int  nerr = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic expect_wb(input logic [1:0] wr, input logic [1:0] r1, input logic [1:0] r2,
                           input logic [2:0] op, input logic sel, input logic [7:0] im);
    wb_t e;
    e.wreg = wr; e.reg1 = r1; e.reg2 = r2; e.alu_op = op; e.wdata_sel = sel; e.imm = im;
    sb.push_back(e);
  endtask

  // Wait for a fetch request at addr, optionally stall, then ack with data
  task automatic serve(input logic [7:0] addr, input logic [7:0] data, input int delay);
    int n = 0;
    while (fetch_req !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check("fetch_timeout", 32'(n >= 50), 0);
    check("imem_addr", imem_addr, addr);
    repeat (delay) begin
      tick();
      check("fetch_hold", fetch_req, 1);
    end
    fetch_ack = 1'b1;
    instr     = data;
    tick();
    fetch_ack = 1'b0;
    instr     = 8'($urandom);
  endtask

  // Assert reset, check the cleared outputs, release, check INIT then FETCH
  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("rst_rf_we", rf_we, 0);
    check("rst_rf_reset", rf_reset, 0);
    check("rst_fetch_req", fetch_req, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_halted", halted, 0);
    check("rst_wreg", wreg, 0);
    check("rst_imm", imm, 0);
    check("rst_wdata_sel", wdata_sel, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("init_rf_reset", rf_reset, 1);
    check("init_fetch_req", fetch_req, 0);
    tick();
    check("init_rf_reset_drop", rf_reset, 0);
    check("init_fetch_req_up", fetch_req, 1);
    check("init_addr", imem_addr, 0);
  endtask

  // Scoreboard monitor: every write-back must match the next expected entry
  always @(negedge clk) begin
    if (reset === 1'b0 && rf_we === 1'b1) begin
      if (sb.size() == 0) begin
        check("we_unexpected", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check("wb_wreg", wreg, mon_e.wreg);
        check("wb_reg1", reg1, mon_e.reg1);
        check("wb_reg2", reg2, mon_e.reg2);
        check("wb_alu_op", alu_op, mon_e.alu_op);
        check("wb_wdata_sel", wdata_sel, mon_e.wdata_sel);
        if (mon_e.wdata_sel) check("wb_imm", imm, mon_e.imm);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [7:0] pc;
    logic [1:0] rd, rs;
    reset     = 1'b1;
    fetch_ack = 1'b0;
    instr     = '0;
    reg1data  = '0;
    repeat (2) tick();
    do_reset();

    // fetch_ack held low: stays in FETCH at address 0
    repeat (3) begin
      tick();
      check("idle_fetch_req", fetch_req, 1);
      check("idle_addr", imem_addr, 0);
    end

    // ADD r1,r2; a stray ack during DECODE/WB must be ignored
    expect_wb(2'd1, 2'd1, 2'd2, 3'd1, 1'b0, 8'h00);
    serve(8'h00, 8'h26, 0);
    fetch_ack = 1'b1;
    instr     = 8'hFF;
    tick();
    tick();
    fetch_ack = 1'b0;

    // LDI r3, 0xA5
    expect_wb(2'd3, 2'd3, 2'd0, 3'd0, 1'b1, 8'hA5);
    serve(8'h01, 8'h8C, 0);
    serve(8'h02, 8'hA5, 0);

    // NOP with a stalled ack
    serve(8'h03, 8'h00, 2);
    check("nop_illegal", illegal, 0);

    // Illegal opcode: one-cycle pulse, no write
    serve(8'h04, 8'hB0, 0);
    check("illegal_pulse", illegal, 1);
    check("illegal_no_we", rf_we, 0);
    tick();
    check("illegal_drop", illegal, 0);

    // Every ALU opcode with random operands
    pc = 8'h05;
    for (int op = 1; op <= 7; op++) begin
      rd = 2'($urandom_range(0, 3));
      rs = 2'($urandom_range(0, 3));
      expect_wb(rd, rd, rs, 3'(op - 1), 1'b0, 8'h00);
      serve(pc, {4'(op), rd, rs}, op % 2);
      pc = pc + 8'd1;
    end

    // BRZ taken
    reg1data = 8'h00;
    serve(8'h0C, 8'hA4, 0);
    check("brz_reg1", reg1, 1);
    serve(8'h0D, 8'h40, 0);
    // BRZ not taken
    reg1data = 8'h07;
    serve(8'h40, 8'hA4, 0);
    serve(8'h41, 8'h40, 1);
    // JMP to 0xFE, then two NOPs wrap the PC to 0x00
    serve(8'h42, 8'h90, 0);
    serve(8'h43, 8'hFE, 0);
    serve(8'hFE, 8'h00, 0);
    serve(8'hFF, 8'h00, 0);

    // HALT: no fetches and no writes even with ack held high
    serve(8'h00, 8'hF0, 0);
    tick();
    fetch_ack = 1'b1;
    for (int i = 0; i < 20; i++) begin
      check("halt_halted", halted, 1);
      check("halt_fetch_req", fetch_req, 0);
      check("halt_rf_we", rf_we, 0);
      tick();
    end
    fetch_ack = 1'b0;
    check("sb_drain_1", sb.size(), 0);

    // Reset in the middle of WB: write is abandoned immediately
    do_reset();
    serve(8'h00, 8'h26, 0);
    @(posedge clk);
    #2;
    check("wb_before_reset", rf_we, 1);
    do_reset();

    // Reset while an immediate fetch is stalled for 5 cycles
    serve(8'h00, 8'h8C, 0);
    tick();
    check("imm_fetch_req", fetch_req, 1);
    check("imm_addr", imem_addr, 1);
    repeat (5) begin
      tick();
      check("imm_stall", fetch_req, 1);
    end
    check("imm_reg1", reg1, 3);
    do_reset();

    // Normal operation resumes after reset
    expect_wb(2'd1, 2'd1, 2'd2, 3'd1, 1'b0, 8'h00);
    serve(8'h00, 8'h26, 0);
    serve(8'h01, 8'h00, 0);
    check("sb_drain_2", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
